flow_seq_ctrl: RTL and testbench

Sequencer for the microfluidic flow-control processor: owns the program counter's control inputs (`pchalt`, `delay`, `count_done`), fetches each instruction from instruction memory, executes valve-write, wait and halt opcodes, and times WAIT intervals in real-time ticks. It sits between the start/abort controls and the program counter, instruction memory and valve register bank.

---
 rtl/flow_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_flow_seq_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flow_seq_ctrl.sv
// Sequencer for the microfluidic flow-control processor: fetches instructions,
// drives the PC control lines, issues valve writes and times WAIT intervals.
module flow_seq_ctrl #(
  parameter int MEM_LAT  = 1,
  parameter int TICK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] instr,
  output logic        pc_clr,
  output logic        pchalt,
  output logic        delay,
  output logic        count_done,
  output logic        valve_we,
  output logic [3:0]  valve_addr,
  output logic [7:0]  valve_data,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int FW = (MEM_LAT  > 1) ? $clog2(MEM_LAT)  : 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [FW-1:0] FETCH_LAST = FW'(MEM_LAT - 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_SETV = 4'h1;
  localparam logic [3:0] OP_WAIT = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALTED
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     ir;
  logic [FW-1:0]   fetch_cnt;
  logic [PW-1:0]   presc;
  logic [11:0]     ticks;
  logic            halt_seen;
  logic            err_seen;
  logic [3:0]      opcode;
  logic            fetch_end;
  logic            wait_end;
  logic            legal_op;

  assign opcode    = ir[15:12];
  assign fetch_end = (fetch_cnt == FETCH_LAST);
  assign wait_end  = (ticks == ir[11:0]);
  assign legal_op  = (opcode == OP_NOP) || (opcode == OP_SETV) ||
                     (opcode == OP_WAIT) || (opcode == OP_HALT);

  assign done = (state == S_HALTED) && halt_seen;
  assign err  = err_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Moore decode: every output depends only on registered state, IR and counters.
  always_comb begin
    state_nxt  = state;
    pc_clr     = 1'b0;
    pchalt     = 1'b1;
    delay      = 1'b0;
    count_done = 1'b0;
    valve_we   = 1'b0;
    valve_addr = 4'd0;
    valve_data = 8'd0;
    busy       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start && !abort) state_nxt = S_CLR;
      end
      S_CLR: begin
        pc_clr    = 1'b1;
        busy      = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        busy = 1'b1;
        if (fetch_end) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        case (opcode)
          OP_NOP: begin
            pchalt    = 1'b0;
            state_nxt = S_FETCH;
          end
          OP_SETV: begin
            pchalt     = 1'b0;
            valve_we   = 1'b1;
            valve_addr = ir[11:8];
            valve_data = ir[7:0];
            state_nxt  = S_FETCH;
          end
          OP_WAIT: state_nxt = S_WAIT;
          default: state_nxt = S_HALTED;
        endcase
      end
      S_WAIT: begin
        busy       = 1'b1;
        pchalt     = 1'b0;
        delay      = 1'b1;
        count_done = wait_end;
        if (wait_end) state_nxt = S_FETCH;
      end
      S_HALTED: begin
      end
      default: state_nxt = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) state_nxt = S_HALTED;
  end

  // Counters only run while their state persists, so any exit (abort included) clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= 16'd0;
      fetch_cnt <= '0;
      presc     <= '0;
      ticks     <= 12'd0;
      halt_seen <= 1'b0;
      err_seen  <= 1'b0;
    end else begin
      if ((state == S_FETCH) && (state_nxt == S_FETCH)) begin
        fetch_cnt <= fetch_cnt + 1'b1;
      end else begin
        fetch_cnt <= '0;
      end

      if ((state == S_FETCH) && (state_nxt == S_EXEC)) begin
        ir <= instr;
      end

      if ((state == S_WAIT) && (state_nxt == S_WAIT)) begin
        if (presc == PRESC_LAST) begin
          presc <= '0;
          ticks <= ticks + 12'd1;
        end else begin
          presc <= presc + 1'b1;
        end
      end else begin
        presc <= '0;
        ticks <= 12'd0;
      end

      if ((state == S_EXEC) && !abort) begin
        if (opcode == OP_HALT) halt_seen <= 1'b1;
        else if (!legal_op)    err_seen  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flow_seq_ctrl.sv
// Self-checking bench for flow_seq_ctrl: a trace-level reference model expands each
// program into its expected per-cycle outputs and the PC it should produce.
module tb_flow_seq_ctrl;

  localparam int MEM_LAT  = 3;
  localparam int TICK_DIV = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_END  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] instr;
  logic        pc_clr, pchalt, delay, count_done, valve_we, busy, done, err;
  logic [3:0]  valve_addr;
  logic [7:0]  valve_data;

  always #5 clk = ~clk;

  flow_seq_ctrl #(.MEM_LAT(MEM_LAT), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .instr(instr),
    .pc_clr(pc_clr), .pchalt(pchalt), .delay(delay), .count_done(count_done),
    .valve_we(valve_we), .valve_addr(valve_addr), .valve_data(valve_data),
    .busy(busy), .done(done), .err(err)
  );

  // Program counter and instruction memory with MEM_LAT read latency
  logic [15:0] mem [256];
  logic [7:0]  pc;
  int unsigned age;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pc  <= 8'd0;
      age <= 0;
    end else if (pc_clr) begin
      pc  <= 8'd0;
      age <= 0;
    end else if (!pchalt && (!delay || count_done)) begin
      pc  <= pc + 8'd1;
      age <= 0;
    end else if (age < 1000) begin
      age <= age + 1;
    end
  end

  assign instr = (age >= MEM_LAT - 1) ? mem[pc] : 16'hD00D;

  typedef struct packed {
    logic [7:0] pc;
    logic       pc_clr, pchalt, delay, count_done, valve_we;
    logic [3:0] va;
    logic [7:0] vd;
    logic       busy, done, err;
  } cyc_t;

  cyc_t q[$];
  cyc_t term = '0;
  int   mode = M_IDLE;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_delay = 0, n_cd = 0, cd_at = 0, n_we = 0;
  logic [3:0] last_va = 4'd0;
  logic [7:0] last_vd = 8'd0;

  function automatic cyc_t mk(input logic [7:0] p);
    cyc_t c = '0;
    c.pc     = p;
    c.pchalt = 1'b1;
    return c;
  endfunction

  // Expand the program from address 0 into one expected entry per clock cycle
  task automatic build_trace(input logic [7:0] pc_now);
    logic [7:0]  a;
    logic [15:0] ins;
    cyc_t        c;
    int          n;
    q.delete();
    a = 8'd0;
    c = mk(pc_now); c.pc_clr = 1'b1; c.busy = 1'b1; q.push_back(c);
    for (int k = 0; k < 512; k++) begin
      for (int j = 0; j < MEM_LAT; j++) begin
        c = mk(a); c.busy = 1'b1; q.push_back(c);
      end
      ins = mem[a];
      c = mk(a); c.busy = 1'b1;
      case (ins[15:12])
        4'h0: begin c.pchalt = 1'b0; q.push_back(c); a++; end
        4'h1: begin
          c.pchalt = 1'b0; c.valve_we = 1'b1; c.va = ins[11:8]; c.vd = ins[7:0];
          q.push_back(c); a++;
        end
        4'h2: begin
          q.push_back(c);
          n = int'(ins[11:0]) * TICK_DIV + 1;
          for (int j = 0; j < n; j++) begin
            c = mk(a); c.pchalt = 1'b0; c.delay = 1'b1; c.busy = 1'b1;
            c.count_done = (j == n - 1);
            q.push_back(c);
          end
          a++;
        end
        4'hF: begin q.push_back(c); term = mk(a); term.done = 1'b1; return; end
        default: begin q.push_back(c); term = mk(a); term.err = 1'b1; return; end
      endcase
    end
    term = mk(a);
  endtask

  function automatic cyc_t exp_now();
    if (mode == M_RUN && q.size() > 0) return q[0];
    if (mode == M_END) return term;
    return mk(8'd0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, expv, $time);
    end
  endtask

  // Compare the DUT against the model every cycle, then advance the model
  initial begin
    cyc_t e;
    cyc_t a;
    forever begin
      @(negedge clk);
      if (rst) begin
        mode = M_IDLE;
        q.delete();
      end
      e = exp_now();
      a = {pc, pc_clr, pchalt, delay, count_done, valve_we, valve_addr, valve_data, busy, done, err};
      checkOutput("cycle", {4'd0, a}, {4'd0, e});
      if (delay) n_delay++;
      if (count_done) begin n_cd++; cd_at = n_delay; end
      if (valve_we) begin n_we++; last_va = valve_addr; last_vd = valve_data; end
      if (!rst) begin
        case (mode)
          M_IDLE: if (start && !abort) begin build_trace(pc); mode = M_RUN; end
          M_RUN: begin
            void'(q.pop_front());
            if (abort) begin
              term.done = 1'b0;
              term.err  = 1'b0;
              if (q.size() > 0) term.pc = q[0].pc;
              q.delete();
              mode = M_END;
            end else if (q.size() == 0) begin
              mode = M_END;
            end
          end
          default: ;
        endcase
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counters;
    n_delay = 0; n_cd = 0; cd_at = 0; n_we = 0; last_va = 4'd0; last_vd = 8'd0;
  endtask

  task automatic clear_mem;
    for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    tick; tick;
    rst = 1'b0;
    clear_counters();
  endtask

  task automatic applyStimulus(input int max_cycles, input int abort_rate, input bit poke);
    int c;
    start = 1'b1; tick; start = 1'b0;
    for (c = 0; c < max_cycles; c++) begin
      tick;
      if (mode == M_END) break;
      start = poke && ($urandom_range(7) == 0);
      abort = (abort_rate > 0) && ($urandom_range(abort_rate - 1) == 0);
    end
    start = 1'b0; abort = 1'b0;
    if (c >= max_cycles) checkOutput("timeout", 32'(mode), 32'(M_END));
    repeat (3) tick;
  endtask

  initial begin
    int len, sel;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    clear_mem();
    tick; tick;
    do_reset();
    checkOutput("reset_outputs",
      {12'd0, pc_clr, pchalt, delay, count_done, valve_we, valve_addr, valve_data, busy, done, err},
      32'h0004_0000);

    // SETV 3,0xA5; NOP; HALT
    mem[0] = 16'h13A5; mem[1] = 16'h0000; mem[2] = 16'hF000;
    applyStimulus(200, 0, 1'b0);
    checkOutput("t1_we_count", 32'(n_we), 32'd1);
    checkOutput("t1_valve", {24'd0, last_va, 4'd0} | 32'(last_vd) << 16, {24'd0, 4'd3, 4'd0} | 32'hA5 << 16);
    checkOutput("t1_done_busy_pc", {22'd0, done, busy, pc}, {22'd0, 1'b1, 1'b0, 8'd2});

    // WAIT 3; HALT
    do_reset(); clear_mem();
    mem[0] = 16'h2003;
    applyStimulus(200, 0, 1'b0);
    checkOutput("t2_delay_cycles", 32'(n_delay), 32'd13);
    checkOutput("t2_cd_count", 32'(n_cd), 32'd1);
    checkOutput("t2_cd_position", 32'(cd_at), 32'd13);
    checkOutput("t2_pc", 32'(pc), 32'd1);

    // WAIT 0; HALT
    do_reset(); clear_mem();
    mem[0] = 16'h2000;
    applyStimulus(200, 0, 1'b0);
    checkOutput("t3_delay_cycles", 32'(n_delay), 32'd1);
    checkOutput("t3_cd_count", 32'(n_cd), 32'd1);

    // Abort during tick 2 of WAIT 5, then a start that must be ignored
    do_reset(); clear_mem();
    mem[0] = 16'h2005;
    start = 1'b1; tick; start = 1'b0;
    for (int c = 0; c < 200 && n_delay < 10; c++) tick;
    checkOutput("t4_reached_wait", 32'(n_delay >= 10), 32'd1);
    abort = 1'b1; tick; abort = 1'b0;
    repeat (5) tick;
    checkOutput("t4_after_abort", {20'd0, n_cd[0], done, busy, err, pc}, {20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});
    start = 1'b1; tick; start = 1'b0;
    repeat (10) tick;
    checkOutput("t4_start_ignored", {30'd0, busy, pc_clr}, 32'd0);

    // Illegal opcode 0x7 at address 1
    do_reset(); clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h7123; mem[2] = 16'h13A5;
    applyStimulus(200, 0, 1'b0);
    checkOutput("t5_err_done_pc", {22'd0, err, done, pc}, {22'd0, 1'b1, 1'b0, 8'd1});
    checkOutput("t5_no_we", 32'(n_we), 32'd0);

    // Asynchronous reset in the middle of FETCH
    do_reset(); clear_mem();
    mem[0] = 16'h0000; mem[1] = 16'h0000;
    start = 1'b1; tick; start = 1'b0;
    tick; tick;
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_async_reset",
      {12'd0, pc_clr, pchalt, delay, count_done, valve_we, valve_addr, valve_data, busy, done, err},
      32'h0004_0000);
    tick;
    rst = 1'b0;
    repeat (4) tick;
    checkOutput("t6_stays_idle", {31'd0, busy}, 32'd0);
    applyStimulus(200, 0, 1'b0);
    checkOutput("t6_restart", {23'd0, done, pc}, {23'd0, 1'b1, 8'd2});

    // Longest wait: N = 4095
    do_reset(); clear_mem();
    mem[0] = 16'h2FFF;
    applyStimulus(20000, 0, 1'b0);
    checkOutput("t7_delay_cycles", 32'(n_delay), 32'd16381);
    checkOutput("t7_cd_pc", {23'd0, n_cd[0], pc}, {23'd0, 1'b1, 8'd1});

    // Random programs, some with random aborts and stray start pulses
    for (int r = 0; r < 12; r++) begin
      do_reset(); clear_mem();
      len = $urandom_range(6, 1);
      for (int i = 0; i < len; i++) begin
        sel = $urandom_range(9);
        if (sel < 3)      mem[i] = {4'h0, 12'($urandom)};
        else if (sel < 6) mem[i] = {4'h1, 12'($urandom)};
        else if (sel < 9) mem[i] = {4'h2, 12'($urandom_range(5))};
        else              mem[i] = {4'($urandom_range(14, 3)), 12'($urandom)};
      end
      applyStimulus(3000, (r % 2 == 1) ? 40 : 0, 1'b1);
    end

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
